// File: rtl/axi4_rd_arb.sv
// ============================================================================
// Module      : axi4_rd_arb
// Description : Round-robin arbiter funnelling NB_REQ read requesters onto one
//               AXI4 master read port, one outstanding burst at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_rd_arb #(
    parameter int NB_REQ      = 4,
    parameter int AXI4_DATA_W = 32,
    parameter int AXI4_ADD_W  = 10,
    parameter int AXI4_ID_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_REQ-1:0]            req_arvalid,
    input  logic [NB_REQ*AXI4_ADD_W-1:0] req_araddr,
    input  logic [NB_REQ*8-1:0]          req_arlen,
    output logic [NB_REQ-1:0]            req_arready,
    output logic [NB_REQ-1:0]            req_rvalid,
    output logic [NB_REQ-1:0]            req_rlast,
    output logic [AXI4_DATA_W-1:0]       req_rdata,
    output logic [1:0]                   req_rresp,
    input  logic [NB_REQ-1:0]            req_rready,
    output logic [AXI4_ID_W-1:0]         m_arid,
    output logic [AXI4_ADD_W-1:0]        m_araddr,
    output logic [7:0]                   m_arlen,
    output logic [2:0]                   m_arsize,
    output logic [1:0]                   m_arburst,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    input  logic [AXI4_ID_W-1:0]         m_rid,
    input  logic [AXI4_DATA_W-1:0]       m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rlast,
    input  logic                         m_rvalid,
    output logic                         m_rready,
    output logic                         err
);

    localparam int         c_GW     = $clog2(NB_REQ);
    localparam logic [2:0] c_ARSIZE = 3'($clog2(AXI4_DATA_W/8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_GW-1:0]         r_grant;
    logic [c_GW-1:0]         r_rr_ptr;
    logic [AXI4_ADD_W-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [8:0]              r_beat_cnt;
    logic                    r_err;

    logic [c_GW-1:0]         w_sel;
    logic                    w_any;
    logic                    w_rready;
    logic                    w_beat;
    logic                    w_err_evt;

    // Scan from the highest offset down so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_sel = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(r_rr_ptr) + k;
            if (j >= NB_REQ) j = j - NB_REQ;
            if (req_arvalid[j]) w_sel = c_GW'(j);
        end
    end

    assign w_any    = |req_arvalid;
    assign w_rready = (r_state == S_DATA) && req_rready[r_grant];
    assign w_beat   = w_rready && m_rvalid;

    assign w_err_evt = (m_rvalid && (r_state != S_DATA)) ||
                       (w_beat && ((m_rid != AXI4_ID_W'(r_grant)) ||
                                   ( m_rlast && (r_beat_cnt != {1'b0, r_len})) ||
                                   (!m_rlast && (r_beat_cnt == {1'b0, r_len}))));

    always_comb begin
        w_state_nxt = r_state;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        req_arready = '0;
        req_rvalid  = '0;
        req_rlast   = '0;
        req_rdata   = '0;
        req_rresp   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                m_arvalid            = 1'b1;
                req_arready[r_grant] = m_arready;
                if (m_arready) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                m_rready            = w_rready;
                req_rvalid[r_grant] = m_rvalid;
                req_rlast[r_grant]  = m_rlast;
                req_rdata           = m_rdata;
                req_rresp           = m_rresp;
                if (w_beat && m_rlast) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_any) begin
                r_grant  <= w_sel;
                r_addr   <= req_araddr[int'(w_sel)*AXI4_ADD_W +: AXI4_ADD_W];
                r_len    <= req_arlen[int'(w_sel)*8 +: 8];
                r_rr_ptr <= (w_sel == c_GW'(NB_REQ - 1)) ? '0 : w_sel + 1'b1;
            end
            if ((r_state == S_ADDR) && m_arready) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if (w_err_evt) r_err <= 1'b1;
        end
    end

    assign m_arid    = AXI4_ID_W'(r_grant);
    assign m_araddr  = r_addr;
    assign m_arlen   = r_len;
    assign m_arsize  = c_ARSIZE;
    assign m_arburst = 2'b01;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axi4_rd_arb.sv
// ============================================================================
// Module      : tb_axi4_rd_arb
// Description : Directed self-checking bench for axi4_rd_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_rd_arb;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     req_arvalid;
    logic [NB*AW-1:0]  req_araddr;
    logic [NB*8-1:0]   req_arlen;
    logic [NB-1:0]     req_arready;
    logic [NB-1:0]     req_rvalid;
    logic [NB-1:0]     req_rlast;
    logic [DW-1:0]     req_rdata;
    logic [1:0]        req_rresp;
    logic [NB-1:0]     req_rready;
    logic [IW-1:0]     m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [IW-1:0]     m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_rd_arb #(
        .NB_REQ(NB), .AXI4_DATA_W(DW), .AXI4_ADD_W(AW), .AXI4_ID_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rlast(req_rlast),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rready(req_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [7:0] l);
        req_araddr[idx*AW +: AW] = a;
        req_arlen[idx*8 +: 8]    = l;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        #3;
        checks++;
        if ({m_arvalid, m_rready, err} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b required 000", {m_arvalid, m_rready, err});
        end
        checks++;
        if ({req_arready, req_rvalid, req_rlast} !== 12'h000) begin
            errors++; $display("FAIL reset_req got %h required 000", {req_arready, req_rvalid, req_rlast});
        end
        checks++;
        if ({m_araddr, m_arlen, m_arid} !== 26'd0) begin
            errors++; $display("FAIL reset_ar got %h required 0", {m_araddr, m_arlen, m_arid});
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        set_req(2, 10'h040, 8'd3);
        req_arvalid = 4'b0100;
        step();
        req_arvalid = '0;
        #1;
        checks++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst} !==
            {1'b1, 8'd2, 10'h040, 8'd3, 3'd2, 2'b01}) begin
            errors++; $display("FAIL single_ar got v%b id%h a%h l%h s%h b%h required v1 id02 a040 l03 s2 b1",
                               m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst);
        end
        checks++;
        if (req_arready !== 4'b0000) begin
            errors++; $display("FAIL single_arready_early got %b required 0000", req_arready);
        end
        step();
        #1;
        checks++;
        if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, 10'h040, 8'd3}) begin
            errors++; $display("FAIL single_hold got v%b a%h l%h required v1 a040 l03", m_arvalid, m_araddr, m_arlen);
        end
        step();
        m_arready = 1'b1;
        #1;
        checks++;
        if (req_arready !== 4'b0100) begin
            errors++; $display("FAIL single_arready got %b required 0100", req_arready);
        end
        step();
        m_arready = 1'b0;
        #1;
        checks++;
        if ({req_arready, m_arvalid} !== 5'b00000) begin
            errors++; $display("FAIL single_arready_pulse got %b required 00000", {req_arready, m_arvalid});
        end
        req_rready = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rid = 8'd2; m_rdata = 32'hA000_0000 + b; m_rlast = (b == 3);
            #1;
            checks++;
            if ({req_rvalid, m_rready} !== 5'b01001 || req_rdata !== 32'hA000_0000 + b) begin
                errors++; $display("FAIL single_beat%0d got rv%b mr%b d%h required rv0100 mr1 d%h",
                                   b, req_rvalid, m_rready, req_rdata, 32'hA000_0000 + b);
            end
            checks++;
            if (req_rlast !== ((b == 3) ? 4'b0100 : 4'b0000)) begin
                errors++; $display("FAIL single_rlast%0d got %b", b, req_rlast);
            end
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if ({err, m_rready, req_rvalid} !== 6'b000000) begin
            errors++; $display("FAIL single_end got err%b mr%b rv%b required all 0", err, m_rready, req_rvalid);
        end
    endtask

    task automatic test_contention;
        logic [7:0]    exp_g [4] = '{8'd0, 8'd1, 8'd3, 8'd0};
        logic [AW-1:0] exp_a [4] = '{10'h010, 10'h020, 10'h3F0, 10'h010};
        logic [3:0]    oh;
        do_reset();
        set_req(0, 10'h010, 8'd0);
        set_req(1, 10'h020, 8'd0);
        set_req(3, 10'h3F0, 8'd0);
        req_arvalid = 4'b1011;
        req_rready  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << exp_g[i];
            step();
            m_arready = 1'b1;
            #1;
            checks++;
            if ({m_arvalid, m_arid, m_araddr, req_arready} !== {1'b1, exp_g[i], exp_a[i], oh}) begin
                errors++; $display("FAIL contention_grant%0d got v%b id%h a%h ar%b required id%h a%h ar%b",
                                   i, m_arvalid, m_arid, m_araddr, req_arready, exp_g[i], exp_a[i], oh);
            end
            step();
            m_arready = 1'b0;
            m_rvalid = 1'b1; m_rid = exp_g[i]; m_rlast = 1'b1; m_rdata = 32'(i);
            #1;
            checks++;
            if ({req_rvalid, req_rlast} !== {oh, oh}) begin
                errors++; $display("FAIL contention_route%0d got rv%b rl%b required %b", i, req_rvalid, req_rlast, oh);
            end
            step();
            m_rvalid = 1'b0; m_rlast = 1'b0;
            #1;
            checks++;
            if ({m_arvalid, req_rvalid} !== 5'b00000) begin
                errors++; $display("FAIL contention_idle%0d got v%b rv%b required 0", i, m_arvalid, req_rvalid);
            end
        end
        req_arvalid = '0;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL contention_err got %b required 0", err);
        end
    endtask

    task automatic test_backpressure;
        int beat;
        bit rr;
        do_reset();
        set_req(1, 10'h100, 8'd7);
        req_arvalid = 4'b0010;
        step();
        req_arvalid = '0;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
            rr = (cyc % 2 == 0);
            req_rready = {2'b00, rr, 1'b0};
            m_rvalid = 1'b1; m_rid = 8'd1; m_rdata = 32'hB000_0000 + beat; m_rlast = (beat == 7);
            #1;
            checks++;
            if ({m_rready, req_rvalid} !== {rr, 4'b0010}) begin
                errors++; $display("FAIL bp_ready_c%0d got mr%b rv%b required mr%b rv0010", cyc, m_rready, req_rvalid, rr);
            end
            if (rr) begin
                checks++;
                if (req_rdata !== 32'hB000_0000 + beat) begin
                    errors++; $display("FAIL bp_data%0d got %h required %h", beat, req_rdata, 32'hB000_0000 + beat);
                end
                beat++;
            end
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; req_rready = '0;
        req_arvalid = 4'b0001;
        step();
        #1;
        checks++;
        if ({m_arvalid, m_arid, err} !== {1'b1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL bp_exit got v%b id%h err%b required v1 id00 err0", m_arvalid, m_arid, err);
        end
        req_arvalid = '0;
    endtask

    task automatic test_errors;
        // Wrong ID on a single-beat burst
        do_reset();
        set_req(0, 10'h000, 8'd0);
        req_arvalid = 4'b0001; req_rready = 4'b0001;
        step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'd5; m_rlast = 1'b1;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_rid got %b required 1", err);
        end
        step();
        req_arvalid = '0;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'd0; m_rlast = 1'b1;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b required 1", err);
        end

        // Early last: m_rlast on beat 2 of a len-3 burst
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b required 0", err);
        end
        set_req(0, 10'h000, 8'd3);
        req_arvalid = 4'b0001; req_rready = 4'b0001;
        step();
        req_arvalid = '0;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'd0; m_rlast = 1'b0;
        step();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_false_pos got %b required 0", err);
        end
        m_rlast = 1'b1;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_early_last got %b required 1", err);
        end

        // Missing last: len 1, beat 2 arrives without m_rlast
        do_reset();
        set_req(0, 10'h000, 8'd1);
        req_arvalid = 4'b0001; req_rready = 4'b0001;
        step();
        req_arvalid = '0;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'd0; m_rlast = 1'b0;
        step();
        step();
        m_rlast = 1'b1;
        #1;
        checks++;
        if ({err, m_rready, req_rvalid} !== 6'b110001) begin
            errors++; $display("FAIL err_no_last got err%b mr%b rv%b required err1 mr1 rv0001", err, m_rready, req_rvalid);
        end
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if (m_rready !== 1'b0) begin
            errors++; $display("FAIL err_exit_on_last got mr%b required 0", m_rready);
        end

        // Stray m_rvalid while idle
        do_reset();
        req_rready = 4'b1111;
        m_rvalid = 1'b1;
        #1;
        checks++;
        if ({m_rready, req_rvalid} !== 5'b00000) begin
            errors++; $display("FAIL err_idle_route got mr%b rv%b required 0", m_rready, req_rvalid);
        end
        step();
        m_rvalid = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_idle_rvalid got %b required 1", err);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_req(2, 10'h080, 8'd3);
        req_arvalid = 4'b0100; req_rready = 4'b0100;
        step();
        req_arvalid = '0;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'd2; m_rlast = 1'b0; m_rdata = 32'h1;
        step();
        m_rdata = 32'h2;
        #1;
        checks++;
        if (req_rvalid !== 4'b0100) begin
            errors++; $display("FAIL rstmid_pre got %b required 0100", req_rvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_arvalid, m_rready, err, req_arready, req_rvalid, req_rlast} !== 15'd0) begin
            errors++; $display("FAIL rstmid_ctrl got %h required 0",
                               {m_arvalid, m_rready, err, req_arready, req_rvalid, req_rlast});
        end
        checks++;
        if ({m_araddr, m_arlen, m_arid} !== 26'd0) begin
            errors++; $display("FAIL rstmid_ar got %h required 0", {m_araddr, m_arlen, m_arid});
        end
        m_rvalid = 1'b0; req_rready = '0;
        step();
        rst = 1'b0;
        set_req(2, 10'h0C0, 8'd0);
        set_req(3, 10'h0E0, 8'd0);
        req_arvalid = 4'b1100;
        step();
        #1;
        checks++;
        if ({m_arvalid, m_arid, m_araddr} !== {1'b1, 8'd2, 10'h0C0}) begin
            errors++; $display("FAIL rstmid_rr got v%b id%h a%h required v1 id02 a0c0", m_arvalid, m_arid, m_araddr);
        end
        req_arvalid = '0;
    endtask

    task automatic test_withdrawn;
        do_reset();
        set_req(0, 10'h020, 8'd0);
        set_req(1, 10'h3FF, 8'd0);
        req_arvalid = 4'b0001;
        step();
        req_arvalid = 4'b0010;
        set_req(0, 10'h111, 8'd5);
        #1;
        checks++;
        if ({m_araddr, m_arlen, m_arid} !== {10'h020, 8'd0, 8'd0}) begin
            errors++; $display("FAIL wd_registered got a%h l%h id%h required a020 l00 id00", m_araddr, m_arlen, m_arid);
        end
        step();
        req_arvalid = '0;
        m_arready = 1'b1;
        #1;
        checks++;
        if (req_arready !== 4'b0001) begin
            errors++; $display("FAIL wd_arready got %b required 0001", req_arready);
        end
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'd0; m_rlast = 1'b1; req_rready = 4'b0001;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        step();
        #1;
        checks++;
        if ({m_arvalid, req_arready} !== 5'b00000) begin
            errors++; $display("FAIL wd_no_grant got v%b ar%b required 0", m_arvalid, req_arready);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_withdrawn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

`default_nettype wire
